// File: rtl/ibuf_rd_agu_pkg.sv
// -----------------------------------------------------------------------------
// ibuf_rd_agu_pkg
// Shared widths, the default address limit and the FSM state encoding for the
// instruction-buffer read address generator.
// Ports: none (package).
// -----------------------------------------------------------------------------
package ibuf_rd_agu_pkg;

  localparam int ADDR_W         = 15;     // buffer line address width
  localparam int DATA_W         = 128;    // read beat width
  localparam int LEN_W          = 8;      // burst length field (beats - 1)
  localparam int OSTD_W         = 4;      // outstanding counter, holds 0..15
  localparam int ADDR_LIMIT_DEF = 24576;  // 24 banks x 1024 lines

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } agu_state_e;

endpackage

// File: rtl/ibuf_rd_agu_if.sv
// -----------------------------------------------------------------------------
// ibuf_rd_agu_if
// Bundles the descriptor input, the buffer port-a request/return channel and
// the downstream read stream of the address generator.
//   master : the address generator side (drives requests, consumes returns)
//   slave  : the environment side (descriptor source, buffer, downstream sink)
// -----------------------------------------------------------------------------
interface ibuf_rd_agu_if;
  import ibuf_rd_agu_pkg::*;

  // descriptor
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic [ADDR_W-1:0] desc_stride;
  // buffer port a request
  logic              cen_a;
  logic              wen_a;
  logic [ADDR_W-1:0] addr_a;
  logic              last_a;
  logic              ready_a;
  // buffer port a return
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              rlast_a;
  logic              rready_a;
  // downstream stream
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              done;

  modport master (
    input  desc_valid, desc_addr, desc_len, desc_stride,
    output desc_ready,
    output cen_a, wen_a, addr_a, last_a,
    input  ready_a,
    input  rdata_a, rvalid_a, rlast_a,
    output rready_a,
    output out_valid, out_data, out_last,
    input  out_ready,
    output done
  );

  modport slave (
    output desc_valid, desc_addr, desc_len, desc_stride,
    input  desc_ready,
    input  cen_a, wen_a, addr_a, last_a,
    output ready_a,
    output rdata_a, rvalid_a, rlast_a,
    input  rready_a,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  done
  );

endinterface

// File: rtl/ibuf_addr_wrap.sv
// -----------------------------------------------------------------------------
// ibuf_addr_wrap
// Combinational next-line-address adder with single wrap-around at ADDR_LIMIT.
//   i_addr      : current line address
//   i_stride    : increment
//   o_next_addr : (i_addr + i_stride), minus ADDR_LIMIT once if the 16-bit
//                 sum reaches the limit
// -----------------------------------------------------------------------------
module ibuf_addr_wrap
  import ibuf_rd_agu_pkg::*;
#(
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_stride,
  output logic [ADDR_W-1:0] o_next_addr
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(ADDR_LIMIT);

  // One extra bit so the carry of the sum is visible to the compare.
  logic [ADDR_W:0] w_sum;

  assign w_sum       = {1'b0, i_addr} + {1'b0, i_stride};
  assign o_next_addr = ADDR_W'((w_sum >= LIMIT) ? (w_sum - LIMIT) : w_sum);

endmodule

// File: rtl/ibuf_rd_agu.sv
// -----------------------------------------------------------------------------
// ibuf_rd_agu
// Turns one burst descriptor into per-beat buffer read requests (with last
// marking), limits accepted-but-unreturned beats to OSTD_MAX, forwards the
// returned beats downstream with zero latency and pulses done when the final
// beat of the burst has been delivered.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : ibuf_rd_agu_if.master (descriptor, port a, downstream, done)
// Build option: IBUF_RD_AGU_STRIDE_EN defined -> desc_stride is the per-beat
// increment; undefined -> desc_stride is ignored and the increment is 1.
// -----------------------------------------------------------------------------
module ibuf_rd_agu
  import ibuf_rd_agu_pkg::*;
#(
  parameter int OSTD_MAX   = 4,
  parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  ibuf_rd_agu_if.master  bus
);

  agu_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, w_incr, w_next_addr;
  logic [LEN_W-1:0]  r_len, r_beat;
  logic [OSTD_W-1:0] r_ostd;
  logic              r_done;
  logic              w_cen, w_desc_ready, w_desc_hs, w_req_hs, w_ret_hs;
  logic              w_burst_end;

`ifdef IBUF_RD_AGU_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;
  assign w_incr = r_stride;
`else
  logic              w_unused_stride;
  assign w_unused_stride = ^bus.desc_stride;
  assign w_incr          = ADDR_W'(1);
`endif

  ibuf_addr_wrap #(.ADDR_LIMIT(ADDR_LIMIT)) u_wrap (
    .i_addr      (r_addr),
    .i_stride    (w_incr),
    .o_next_addr (w_next_addr)
  );

  assign w_desc_hs   = w_desc_ready && bus.desc_valid && !rst;
  assign w_req_hs    = w_cen && bus.ready_a;
  assign w_ret_hs    = bus.rvalid_a && bus.out_ready;
  // Final return: only one beat left outstanding and it carries rlast.
  assign w_burst_end = (r_state == DRAIN) && w_ret_hs && bus.rlast_a &&
                       (r_ostd == OSTD_W'(1));

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cen        = 1'b0;
    w_desc_ready = 1'b0;
    case (r_state)
      IDLE: begin
        w_desc_ready = 1'b1;
        if (bus.desc_valid) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_cen = (r_ostd < OSTD_W'(OSTD_MAX));
        if (w_cen && bus.ready_a && (r_beat == r_len)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_burst_end) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset is synchronous, so mask the request side while it is held.
    if (rst) begin
      w_cen        = 1'b0;
      w_desc_ready = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_len  <= '0;
      r_beat <= '0;
      r_ostd <= '0;
      r_done <= 1'b0;
`ifdef IBUF_RD_AGU_STRIDE_EN
      r_stride <= '0;
`endif
    end else begin
      r_done <= w_burst_end;
      if (w_desc_hs) begin
        r_addr <= bus.desc_addr;
        r_len  <= bus.desc_len;
        r_beat <= '0;
`ifdef IBUF_RD_AGU_STRIDE_EN
        r_stride <= bus.desc_stride;
`endif
      end else if (w_req_hs) begin
        r_addr <= w_next_addr;
        r_beat <= r_beat + LEN_W'(1);
      end
      // Simultaneous issue and return cancel out; a stray return never wraps.
      case ({w_req_hs, w_ret_hs})
        2'b10:   r_ostd <= r_ostd + OSTD_W'(1);
        2'b01:   if (r_ostd != '0) r_ostd <= r_ostd - OSTD_W'(1);
        default: r_ostd <= r_ostd;
      endcase
    end
  end

  assign bus.desc_ready = w_desc_ready;
  assign bus.cen_a      = w_cen;
  assign bus.wen_a      = 1'b0;
  assign bus.addr_a     = r_addr;
  assign bus.last_a     = (r_beat == r_len);
  assign bus.done       = r_done && !rst;

  // Read stream is a pure wire-through.
  assign bus.out_valid  = bus.rvalid_a;
  assign bus.out_data   = bus.rdata_a;
  assign bus.out_last   = bus.rlast_a;
  assign bus.rready_a   = bus.out_ready;

endmodule

// File: tb/tb_ibuf_rd_agu.sv
// -----------------------------------------------------------------------------
// tb_ibuf_rd_agu
// Self-checking bench: a transaction-level model (queue of expected beat
// addresses per burst, outstanding count, buffer return queue) is compared
// against the DUT every cycle, plus directed bursts with literal expectations.
// -----------------------------------------------------------------------------
module tb_ibuf_rd_agu;
  import ibuf_rd_agu_pkg::*;

  localparam int OSTD  = 4;
  localparam int LIMIT = 24576;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibuf_rd_agu_if bus_if ();

  ibuf_rd_agu #(.OSTD_MAX(OSTD), .ADDR_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [14:0] addr; logic last; } req_t;
  typedef struct { logic [127:0] data; logic last; int avail; } ret_t;

  req_t m_issue_q[$];
  ret_t buf_q[$];
  int   m_ostd = 0, m_ret_left = 0;
  bit   m_active = 0, m_done_exp = 0;
  int   cyc = 0;

  logic [14:0] log_addr[$];
  logic        log_last[$];
  int n_acc = 0, n_desc = 0, n_done = 0, last_ret_cyc = -1, done_cyc = -1;

  // stimulus knobs
  logic        d_valid = 0;
  logic [14:0] d_addr = 0, d_stride = 0;
  logic [7:0]  d_len = 0;
  int          p_ready = 100, p_out = 100;
  bit          out_hold = 0;

  function automatic logic [14:0] wrap_next(input logic [14:0] a, input logic [14:0] inc);
    int s;
    s = int'(a) + int'(inc);
    if (s >= LIMIT) s -= LIMIT;
    return 15'(s);
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cycle();
    bit   exp_cen, exp_dr, hs_desc, hs_req, hs_ret, ret_vis;
    req_t r;
    logic [14:0] a, inc;
    @(posedge clk); #1;
    cyc++;
    if (rst) buf_q.delete();
    bus_if.desc_valid  = d_valid;
    bus_if.desc_addr   = d_addr;
    bus_if.desc_len    = d_len;
    bus_if.desc_stride = d_stride;
    bus_if.ready_a     = ($urandom_range(99) < p_ready);
    bus_if.out_ready   = out_hold ? 1'b0 : ($urandom_range(99) < p_out);
    ret_vis = (buf_q.size() > 0) && (buf_q[0].avail <= cyc);
    if (ret_vis) begin
      bus_if.rvalid_a = 1'b1;
      bus_if.rdata_a  = buf_q[0].data;
      bus_if.rlast_a  = buf_q[0].last;
    end else begin
      bus_if.rvalid_a = 1'b0;
      bus_if.rdata_a  = {$urandom, $urandom, $urandom, $urandom};
      bus_if.rlast_a  = 1'($urandom_range(1));
    end
    #1;
    exp_cen = !rst && (m_issue_q.size() > 0) && (m_ostd < OSTD);
    exp_dr  = rst || !m_active;
    check("cen_a", bus_if.cen_a, exp_cen);
    check("desc_ready", bus_if.desc_ready, exp_dr);
    check("done", bus_if.done, !rst && m_done_exp);
    check("wen_a", bus_if.wen_a, 1'b0);
    check("out_valid", bus_if.out_valid, bus_if.rvalid_a);
    check("out_data", bus_if.out_data, bus_if.rdata_a);
    check("out_last", bus_if.out_last, bus_if.rlast_a);
    check("rready_a", bus_if.rready_a, bus_if.out_ready);
    if (exp_cen) begin
      check("addr_a", bus_if.addr_a, m_issue_q[0].addr);
      check("last_a", bus_if.last_a, m_issue_q[0].last);
    end
    if (bus_if.done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    hs_desc = d_valid && exp_dr && !rst;
    hs_req  = exp_cen && bus_if.ready_a;
    hs_ret  = ret_vis && bus_if.out_ready && !rst;
    m_done_exp = 0;
    if (rst) begin
      m_issue_q.delete();
      buf_q.delete();
      m_ostd = 0; m_ret_left = 0; m_active = 0;
    end else begin
      if (hs_desc) begin
`ifdef IBUF_RD_AGU_STRIDE_EN
        inc = d_stride;
`else
        inc = 15'd1;
`endif
        a = d_addr;
        for (int k = 0; k <= int'(d_len); k++) begin
          m_issue_q.push_back('{addr: a, last: (k == int'(d_len))});
          a = wrap_next(a, inc);
        end
        m_active = 1; m_ret_left = int'(d_len) + 1; n_desc++;
      end
      if (hs_req) begin
        r = m_issue_q.pop_front();
        log_addr.push_back(r.addr);
        log_last.push_back(r.last);
        buf_q.push_back('{data: {$urandom, $urandom, $urandom, $urandom}, last: r.last,
                          avail: cyc + 1 + int'($urandom_range(3))});
        m_ostd++; n_acc++;
      end
      if (hs_ret) begin
        void'(buf_q.pop_front());
        m_ostd--; m_ret_left--;
        if (m_ret_left == 0) begin
          m_active = 0; m_done_exp = 1; last_ret_cyc = cyc;
        end
      end
    end
  endtask

  task automatic accept_desc(input logic [14:0] a, input logic [7:0] l, input logic [14:0] s);
    int start = n_desc;
    int k = 0;
    d_addr = a; d_len = l; d_stride = s; d_valid = 1;
    while (k < 200 && n_desc == start) begin cycle(); k++; end
    d_valid = 0;
    check("desc_timeout", (n_desc != start), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (k < budget && m_active) begin cycle(); k++; end
    check("burst_timeout", !m_active, 1'b1);
    cycle();  // done pulse window
  endtask

  task automatic run_burst(input logic [14:0] a, input logic [7:0] l, input logic [14:0] s);
    accept_desc(a, l, s);
    wait_idle(4000);
  endtask

  int acc0, done0, desc0, k;

  initial begin
    bus_if.desc_valid = 0; bus_if.ready_a = 0; bus_if.out_ready = 0;
    bus_if.rvalid_a = 0; bus_if.rlast_a = 0; bus_if.rdata_a = '0;
    bus_if.desc_addr = '0; bus_if.desc_len = '0; bus_if.desc_stride = '0;
    rst = 1;
    repeat (3) cycle();
    rst = 0;
    repeat (2) cycle();

    // Four beats from 0x10, everything always ready.
    p_ready = 100; p_out = 100;
    log_addr.delete(); log_last.delete(); done0 = n_done;
    run_burst(15'h0010, 8'd3, 15'd1);
    check("t1_beats", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("t1_addr", log_addr[i], 15'h0010 + 15'(i));
      check("t1_last", log_last[i], (i == 3));
    end
    check("t1_done_cnt", n_done - done0, 1);
    check("t1_done_cyc", done_cyc, last_ret_cyc + 1);

    // Wrap at the top of the buffer.
    log_addr.delete(); log_last.delete();
    run_burst(15'd24574, 8'd2, 15'd1);
    check("t2_beats", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      check("t2_a0", log_addr[0], 15'd24574);
      check("t2_a1", log_addr[1], 15'd24575);
      check("t2_a2", log_addr[2], 15'd0);
    end

    // Outstanding limit with a stalled downstream.
    acc0 = n_acc; out_hold = 1;
    accept_desc(15'd100, 8'd7, 15'd1);
    repeat (20) cycle();
    check("t3_stall_acc", n_acc - acc0, OSTD);
    check("t3_stall_cen", bus_if.cen_a, 1'b0);
    out_hold = 0;
    wait_idle(400);
    check("t3_total_acc", n_acc - acc0, 8);

    // Single beat; a descriptor offered during DRAIN is refused.
    log_addr.delete(); log_last.delete();
    out_hold = 1; desc0 = n_desc;
    accept_desc(15'd5, 8'd0, 15'd1);
    repeat (6) cycle();
    d_addr = 15'd77; d_len = 8'd2; d_valid = 1;
    repeat (5) cycle();
    d_valid = 0;
    check("t4_no_desc", n_desc - desc0, 1);
    out_hold = 0;
    wait_idle(400);
    check("t4_beats", log_addr.size(), 1);
    if (log_addr.size() == 1) check("t4_last", log_last[0], 1'b1);

    // Reset while the second beat of six is on the bus.
    log_addr.delete(); log_last.delete();
    acc0 = n_acc; done0 = n_done; out_hold = 1;
    accept_desc(15'd300, 8'd5, 15'd1);
    k = 0;
    while (k < 50 && log_addr.size() < 1) begin cycle(); k++; end
    check("t5_first_beat", log_addr.size(), 1);
    rst = 1;
    cycle();
    rst = 0;
    cycle();
    check("t5_cen", bus_if.cen_a, 1'b0);
    check("t5_desc_ready", bus_if.desc_ready, 1'b1);
    out_hold = 0;
    repeat (6) cycle();
    check("t5_acc", n_acc - acc0, 1);
    check("t5_no_done", n_done - done0, 0);

    // Bank-stride burst.
    log_addr.delete(); log_last.delete();
    run_burst(15'd0, 8'd2, 15'd1024);
    check("t6_beats", log_addr.size(), 3);
    for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
`ifdef IBUF_RD_AGU_STRIDE_EN
      check("t6_bank", log_addr[i], 15'(i * 1024));
`else
      check("t6_incr", log_addr[i], 15'(i));
`endif
    end

    // Randomized bursts against the model.
    for (int b = 0; b < 40; b++) begin
      logic [14:0] ra, rs;
      logic [7:0]  rl;
      p_ready = 20 + int'($urandom_range(80));
      p_out   = 20 + int'($urandom_range(80));
      ra = 15'($urandom_range(LIMIT - 1));
      rl = ($urandom_range(7) == 0) ? 8'($urandom_range(40)) : 8'($urandom_range(7));
      case ($urandom_range(3))
        0: rs = 15'd0;
        1: rs = 15'd1;
        2: rs = 15'd1024;
        default: rs = 15'($urandom);
      endcase
      repeat ($urandom_range(3)) cycle();
      run_burst(ra, rl, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
